// File: rtl/i2c_byte_engine.sv
// i2c_byte_engine: I2C master byte engine executing START, WRITE, READ and STOP commands on open-drain lines
// Parameter QUARTER_DIV: clk cycles per quarter SCL bit period (2..4095).
// Optional feature macro I2C_CLOCK_STRETCH_EN: honour slave clock stretching via scl_in.
// Ports:
//   clk, rst (async, active-low), en (advance enable)
//   cmd_valid/cmd_ready handshake, cmd (0=START 1=WRITE 2=READ 3=STOP), wr_data, tx_nack
//   rd_data (last READ byte), ack_err (last WRITE ACK level), done (one-cycle pulse), busy
//   sda_in/sda_oe, scl_in/scl_oe (oe=1 pulls the line low)
module i2c_byte_engine #(
    parameter int QUARTER_DIV = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] wr_data,
    input  logic       tx_nack,
    output logic [7:0] rd_data,
    output logic       ack_err,
    output logic       done,
    output logic       busy,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic       scl_in,
    output logic       scl_oe
);
    typedef enum logic [2:0] {IDLE, START, BITS, ACK, STOP, DONE} state_t;
    localparam logic [11:0] RELOAD = 12'(QUARTER_DIV - 1);
    state_t      state, state_n;
    logic [11:0] cnt, cnt_n;
    logic [1:0]  q, q_n;
    logic [2:0]  bit_cnt, bit_n;
    logic [7:0]  sh, sh_n, rd_n;
    logic        samp, samp_n, ack_n, is_rd, is_rd_n, nack, nack_n, sda_n, scl_n, stall;
`ifdef I2C_CLOCK_STRETCH_EN
    // a slave holding SCL low while it should be released freezes the quarter at its tick
    assign stall = (q == 2'd1 || q == 2'd2) && !scl_in;
`else
    logic unused_scl;
    assign unused_scl = scl_in;
    assign stall = 1'b0;
`endif
    assign cmd_ready = state == IDLE;
    assign busy      = !cmd_ready;
    assign done      = state == DONE;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        q_n     = q;
        bit_n   = bit_cnt;
        sh_n    = sh;
        samp_n  = samp;
        rd_n    = rd_data;
        ack_n   = ack_err;
        is_rd_n = is_rd;
        nack_n  = nack;
        if (state == IDLE) begin
            if (cmd_valid) begin
                cnt_n   = RELOAD;
                q_n     = 2'd0;
                bit_n   = 3'd0;
                sh_n    = wr_data;
                is_rd_n = cmd == 2'd2;
                nack_n  = tx_nack;
                state_n = cmd == 2'd0 ? START : cmd == 2'd3 ? STOP : BITS;
            end
        end else if (state == DONE) begin
            state_n = IDLE;
        end else if (en) begin
            if (cnt != 12'd0) begin
                cnt_n = cnt - 12'd1;
            end else if (!stall) begin
                cnt_n = RELOAD;
                q_n   = q + 2'd1;
                if (q == 2'd2)
                    samp_n = sda_in;
                if (q == 2'd3) begin
                    // one shifter serves both directions: WRITE drives sh[7], READ collects samples
                    if (state == BITS) begin
                        sh_n    = {sh[6:0], samp};
                        bit_n   = bit_cnt + 3'd1;
                        state_n = bit_cnt == 3'd7 ? ACK : BITS;
                    end else begin
                        state_n = DONE;
                        rd_n    = state == ACK && is_rd ? sh : rd_data;
                        ack_n   = state == ACK && !is_rd ? samp : ack_err;
                    end
                end
            end
        end
        // line levels follow the next state so they switch together with the quarter
        sda_n = state_n == START ? q_n != 2'd0 :
                state_n == STOP  ? q_n <  2'd2 :
                state_n == BITS  ? !is_rd_n && !sh_n[7] :
                state_n == ACK   ? is_rd_n && !nack_n : sda_oe;
        scl_n = state_n == START ? q_n == 2'd3 :
                state_n == STOP  ? q_n == 2'd0 :
                state_n == BITS || state_n == ACK ? q_n == 2'd0 || q_n == 2'd3 : scl_oe;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            q       <= '0;
            bit_cnt <= '0;
            sh      <= '0;
            samp    <= 1'b0;
            rd_data <= 8'h00;
            ack_err <= 1'b0;
            is_rd   <= 1'b0;
            nack    <= 1'b0;
            sda_oe  <= 1'b0;
            scl_oe  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            q       <= q_n;
            bit_cnt <= bit_n;
            sh      <= sh_n;
            samp    <= samp_n;
            rd_data <= rd_n;
            ack_err <= ack_n;
            is_rd   <= is_rd_n;
            nack    <= nack_n;
            sda_oe  <= sda_n;
            scl_oe  <= scl_n;
        end
    end
endmodule

// File: tb/tb_i2c_byte_engine.sv
// tb_i2c_byte_engine: directed self-checking bench for i2c_byte_engine with QUARTER_DIV=4
module tb_i2c_byte_engine;
    logic       clk = 1'b0, rst = 1'b0, en = 1'b1, cmd_valid = 1'b0, cmd_ready;
    logic [1:0] cmd = 2'd0;
    logic [7:0] wr_data = 8'h00, rd_data;
    logic       tx_nack = 1'b0, ack_err, done, busy, sda_in = 1'b1, sda_oe, scl_in = 1'b1, scl_oe;
    int compared = 0, mismatched = 0;
    int lat;
    logic [8:0]  cap;
    logic [35:0] sdt, sct;

    i2c_byte_engine #(.QUARTER_DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .wr_data(wr_data), .tx_nack(tx_nack), .rd_data(rd_data),
        .ack_err(ack_err), .done(done), .busy(busy), .sda_in(sda_in), .sda_oe(sda_oe),
        .scl_in(scl_in), .scl_oe(scl_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
            $error("%s", tag);
        end
    endtask

    // Issue one command and follow it to done. sl[8-i] is the slave SDA level for cell i;
    // traces record line levels mid-quarter (sdt/sct) and sda_oe in Q2 of each cell (cap).
    task automatic run(input logic [1:0] c, input logic [7:0] wd, input logic nk, input logic [8:0] sl,
                       input logic hold, input logic tog, input logic stretch,
                       output int l, output logic [8:0] cp, output logic [35:0] sd, output logic [35:0] sc);
        int n = 0;
        logic armed = 1'b0, fchk = 1'b0, fs = 1'b0, fc = 1'b0;
        @(negedge clk);
        cmd = c; wr_data = wd; tx_nack = nk; cmd_valid = 1'b1;
        @(posedge clk); #1;
        if (!hold) cmd_valid = 1'b0;
        l = 0; cp = '0; sd = '0; sc = '0;
        while (l == 0 && n < 2000) begin
            if (n < 144 && n % 16 == 0) sda_in = sl[8 - n / 16];
            if (n < 144 && n % 4 == 1) begin sd[n / 4] = sda_oe; sc[n / 4] = scl_oe; end
            if (n < 144 && n % 16 == 8) cp[8 - n / 16] = sda_oe;
            if (stretch) scl_in = !(n >= 54 && n < 74);
            if (tog) en = ~en;
            if (tog && !en && !fchk && n >= 100) begin fs = sda_oe; fc = scl_oe; fchk = 1'b1; armed = 1'b1; end
            if (hold && n == 50) check("busy_no_ready", cmd_ready, 1'b0);
            @(posedge clk); #1;
            n++;
            if (armed) begin check("frozen_lines", {sda_oe, scl_oe}, {fs, fc}); armed = 1'b0; end
            if (done) begin
                l = n + 1;
                check("ready_at_done", {cmd_ready, busy}, 2'b01);
            end
        end
        check("done_seen", l != 0, 1'b1);
        cmd_valid = 1'b0; en = 1'b1; scl_in = 1'b1;
        @(posedge clk); #1;
        check("done_one_cycle", {done, cmd_ready}, 2'b01);
    endtask

    initial begin
        #12;
        check("rst_lines", {sda_oe, scl_oe, done}, 3'b000);
        check("rst_regs", {ack_err, rd_data}, 9'h000);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", {cmd_ready, busy}, 2'b10);
        // START
        run(2'd0, 8'h00, 1'b0, 9'h1FF, 1'b0, 1'b0, 1'b0, lat, cap, sdt, sct);
        check("start_lat", lat, 17);
        check("start_sda", sdt[3:0], 4'b1110);
        check("start_scl", sct[3:0], 4'b1000);
        check("start_hold", {sda_oe, scl_oe}, 2'b11);
        // STOP
        run(2'd3, 8'h00, 1'b0, 9'h1FF, 1'b0, 1'b0, 1'b0, lat, cap, sdt, sct);
        check("stop_lat", lat, 17);
        check("stop_sda", sdt[3:0], 4'b0011);
        check("stop_scl", sct[3:0], 4'b0001);
        check("stop_hold", {sda_oe, scl_oe}, 2'b00);
        // WRITE A5, slave ACKs
        run(2'd1, 8'hA5, 1'b0, 9'h1FE, 1'b0, 1'b0, 1'b0, lat, cap, sdt, sct);
        check("wr_lat", lat, 145);
        check("wr_sda", cap, 9'h0B4);
        check("wr_scl", sct, {9{4'b1001}});
        check("wr_ack", ack_err, 1'b0);
        check("wr_hold_scl", scl_oe, 1'b1);
        // WRITE 3C, slave NACKs
        run(2'd1, 8'h3C, 1'b0, 9'h1FF, 1'b0, 1'b0, 1'b0, lat, cap, sdt, sct);
        check("wr2_sda", cap, 9'h186);
        check("wr2_nack", ack_err, 1'b1);
        check("wr2_rd_keep", rd_data, 8'h00);
        // READ 3C with master NACK
        run(2'd2, 8'h00, 1'b1, {8'h3C, 1'b1}, 1'b0, 1'b0, 1'b0, lat, cap, sdt, sct);
        check("rd_lat", lat, 145);
        check("rd_data", rd_data, 8'h3C);
        check("rd_sda", cap, 9'h000);
        check("rd_ack_keep", ack_err, 1'b1);
        // READ 81 with master ACK
        run(2'd2, 8'h00, 1'b0, {8'h81, 1'b1}, 1'b0, 1'b0, 1'b0, lat, cap, sdt, sct);
        check("rd2_data", rd_data, 8'h81);
        check("rd2_sda", cap, 9'h001);
        // WRITE with en toggling and cmd_valid held throughout
        run(2'd1, 8'h55, 1'b0, 9'h1FE, 1'b1, 1'b1, 1'b0, lat, cap, sdt, sct);
        check("tog_lat", lat >= 286 && lat <= 292, 1'b1);
        check("tog_ack", ack_err, 1'b0);
        // slave holds SCL low inside bit 3
        run(2'd1, 8'hF0, 1'b0, 9'h1FE, 1'b0, 1'b0, 1'b1, lat, cap, sdt, sct);
`ifdef I2C_CLOCK_STRETCH_EN
        check("stretch_lat", lat >= 163 && lat <= 170, 1'b1);
`else
        check("stretch_lat", lat, 145);
`endif
        // reset in the middle of a WRITE
        @(negedge clk);
        cmd = 2'd1; wr_data = 8'h00; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (33) @(posedge clk);
        #1;
        check("pre_rst_lines", {busy, scl_oe, sda_oe}, 3'b111);
        #1 rst = 1'b0;
        #1 check("rst_mid_lines", {sda_oe, scl_oe, done}, 3'b000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_nodone", done, 1'b0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_ready", {cmd_ready, done, sda_oe, scl_oe}, 4'b1000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
